// File: rtl/game_pkg.sv
// Shared game-logic definitions: jump state encoding and the button/collision
// bit positions used by every motion block.
package game_pkg;

    typedef enum logic [1:0] {
        ST_GROUND = 2'b00,
        ST_RISE   = 2'b01,
        ST_FALL   = 2'b10
    } jump_state_e;

    // iBtn_state bit positions
    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_JUMP  = 2;

    // iHit bit positions: a 1 means that direction is free of obstacles
    localparam int HIT_UP    = 0;
    localparam int HIT_DOWN  = 1;
    localparam int HIT_RIGHT = 2;
    localparam int HIT_LEFT  = 3;

endpackage

// File: rtl/jump_fsm.sv
// Vertical motion: GROUND/RISE/FALL state machine with its rise-duration counter
// and the jump-button edge history. Advances only on tick.
module jump_fsm
    import game_pkg::*;
#(
    parameter int POS_W      = 13,
    parameter int STEP       = 1,
    parameter int Y_START    = 64,
    parameter int JUMP_TICKS = 150
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             jump_btn,
    input  logic             up_free,
    input  logic             down_free,
    output logic [POS_W-1:0] y,
    output logic [1:0]       state
);

    localparam logic [POS_W-1:0] STEP_W   = POS_W'(STEP);
    localparam logic [POS_W-1:0] Y_INIT   = POS_W'(Y_START);
    localparam logic [POS_W-1:0] Y_MAX    = '1;
    localparam logic [7:0]       CNT_MAX  = 8'(JUMP_TICKS);

    jump_state_e      state_q, state_d;
    logic [POS_W-1:0] y_q, y_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             jump_prev_q, jump_prev_d;
    logic             jump_edge;
    logic [POS_W:0]   y_sum;

    assign jump_edge = !jump_prev_q && jump_btn;
    assign y_sum     = {1'b0, y_q} + {1'b0, STEP_W};

    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        jump_prev_d = jump_prev_q;
        if (tick) begin
            jump_prev_d = jump_btn;
            case (state_q)
                ST_GROUND: begin
                    if (down_free) begin
                        state_d = ST_FALL;
                    end else if (jump_edge) begin
                        state_d = ST_RISE;
                        cnt_d   = '0;
                    end
                end
                ST_RISE: begin
                    // Leaving the rise holds the current height for this tick.
                    if (cnt_q == CNT_MAX || !jump_btn || !up_free) begin
                        state_d = ST_FALL;
                    end else begin
                        y_d   = y_sum[POS_W] ? Y_MAX : y_sum[POS_W-1:0];
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_FALL: begin
                    if (!down_free) begin
                        state_d = ST_GROUND;
                    end else begin
                        y_d = (y_q > STEP_W) ? (y_q - STEP_W) : '0;
                    end
                end
                default: state_d = ST_GROUND;
            endcase
        end
    end

    // Edge history resets to 1 so a button held through reset is not a jump.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_GROUND;
            y_q         <= Y_INIT;
            cnt_q       <= '0;
            jump_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            jump_prev_q <= jump_prev_d;
        end
    end

    assign y     = y_q;
    assign state = state_q;

endmodule

// File: rtl/player_motion.sv
// Player motion top: horizontal walk/scroll logic here, vertical jump in jump_fsm.
// Define PLAYER_MOTION_MAP_SCROLL_EN to scroll the map once the player reaches X_LIMIT.
module player_motion
    import game_pkg::*;
#(
    parameter int POS_W      = 13,
    parameter int STEP       = 1,
    parameter int X_LIMIT    = 300,
    parameter int Y_START    = 64,
    parameter int JUMP_TICKS = 150
) (
    input  logic             clk,
    input  logic             iRST_N,
    input  logic             iTick,
    input  logic [3:0]       iBtn_state,
    input  logic [3:0]       iHit,
    output logic [POS_W-1:0] oPlayer_x,
    output logic [POS_W-1:0] oPlayer_y,
    output logic [POS_W-1:0] oMap_x,
    output logic             oDir,
    output logic [1:0]       oState
);

    localparam logic [POS_W-1:0] STEP_W  = POS_W'(STEP);
    localparam logic [POS_W-1:0] LIMIT_W = POS_W'(X_LIMIT);

    logic [POS_W-1:0] x_q, x_d;
    logic             dir_q, dir_d;
    logic [POS_W:0]   x_sum;
    logic             go_right, go_left;

    assign x_sum    = {1'b0, x_q} + {1'b0, STEP_W};
    assign go_right = iBtn_state[BTN_RIGHT] && iHit[HIT_RIGHT];
    assign go_left  = iBtn_state[BTN_LEFT] && iHit[HIT_LEFT] && (x_q != '0);

`ifdef PLAYER_MOTION_MAP_SCROLL_EN
    localparam logic [POS_W-1:0] MAP_MAX = '1;
    logic [POS_W-1:0] map_q, map_d;
    logic [POS_W:0]   map_sum;
    assign map_sum = {1'b0, map_q} + {1'b0, STEP_W};
`endif

    always_comb begin
        x_d   = x_q;
        dir_d = dir_q;
`ifdef PLAYER_MOTION_MAP_SCROLL_EN
        map_d = map_q;
`endif
        if (iTick) begin
            if (go_right) begin
                dir_d = 1'b1;
                // Player X never passes X_LIMIT; beyond it the world moves instead.
                if (x_q < LIMIT_W) begin
                    x_d = (x_sum > {1'b0, LIMIT_W}) ? LIMIT_W : x_sum[POS_W-1:0];
                end
`ifdef PLAYER_MOTION_MAP_SCROLL_EN
                else begin
                    map_d = map_sum[POS_W] ? MAP_MAX : map_sum[POS_W-1:0];
                end
`endif
            end else if (go_left) begin
                dir_d = 1'b0;
                x_d   = (x_q > STEP_W) ? (x_q - STEP_W) : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge iRST_N) begin
        if (!iRST_N) begin
            x_q   <= '0;
            dir_q <= 1'b1;
        end else begin
            x_q   <= x_d;
            dir_q <= dir_d;
        end
    end

`ifdef PLAYER_MOTION_MAP_SCROLL_EN
    always_ff @(posedge clk or negedge iRST_N) begin
        if (!iRST_N) map_q <= '0;
        else         map_q <= map_d;
    end
    assign oMap_x = map_q;
`else
    assign oMap_x = '0;
`endif

    jump_fsm #(
        .POS_W     (POS_W),
        .STEP      (STEP),
        .Y_START   (Y_START),
        .JUMP_TICKS(JUMP_TICKS)
    ) u_jump (
        .clk      (clk),
        .rst_n    (iRST_N),
        .tick     (iTick),
        .jump_btn (iBtn_state[BTN_JUMP]),
        .up_free  (iHit[HIT_UP]),
        .down_free(iHit[HIT_DOWN]),
        .y        (oPlayer_y),
        .state    (oState)
    );

    assign oPlayer_x = x_q;
    assign oDir      = dir_q;

endmodule
